voice_scheduler: RTL and testbench

//   Dispatches notes from song_reader to a bank of NUM_VOICES note_player voices
//   so chords and overlapping notes can sound together. Each note is buffered in
//   a one-entry pending register, given a free voice by a round-robin search,

---
 rtl/voice_scheduler.sv | 141 ++++++++++++++
 tb/tb_voice_scheduler.sv | 202 ++++++++++++++++++++
 2 files changed

// File: rtl/voice_scheduler.sv
// Buffers one note at a time from song_reader and hands it to a free note_player
// voice chosen by a round-robin search; tracks per-voice busy from done pulses.
module voice_scheduler #(
  parameter int unsigned NUM_VOICES = 3,
  parameter int unsigned NOTE_W     = 6,
  parameter int unsigned DUR_W      = 6
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  play,
  input  logic                  flush,
  input  logic                  new_note,
  input  logic [NOTE_W-1:0]     note,
  input  logic [DUR_W-1:0]      duration,
  input  logic [NUM_VOICES-1:0] voice_done,
  output logic [NUM_VOICES-1:0] voice_load,
  output logic [NOTE_W-1:0]     voice_note,
  output logic [DUR_W-1:0]      voice_duration,
  output logic [NUM_VOICES-1:0] busy,
  output logic                  ready,
  output logic                  overflow
);

  localparam int unsigned IDX_W = (NUM_VOICES > 1) ? $clog2(NUM_VOICES) : 1;

  typedef enum logic [1:0] {IDLE, ALLOC, LOAD} state_e;

  state_e                  state_q, state_d;
  logic [IDX_W-1:0]        rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0]        idx_q, idx_d;
  logic [NOTE_W-1:0]       pend_note_q, pend_note_d;
  logic [DUR_W-1:0]        pend_dur_q, pend_dur_d;
  logic [NUM_VOICES-1:0]   busy_q, busy_d;
  logic                    overflow_q, overflow_d;

  logic                    found;
  logic [IDX_W-1:0]        free_idx;
  logic [IDX_W-1:0]        cand;
  logic [NUM_VOICES-1:0]   load_vec;

  function automatic logic [IDX_W-1:0] wrap_inc(input logic [IDX_W-1:0] i);
    return (i == IDX_W'(NUM_VOICES - 1)) ? '0 : i + IDX_W'(1);
  endfunction

  // First idle voice at or after rr_ptr, wrapping at NUM_VOICES-1.
  always_comb begin
    found    = 1'b0;
    free_idx = rr_ptr_q;
    cand     = rr_ptr_q;
    for (int unsigned i = 0; i < NUM_VOICES; i++) begin
      if (!found && !busy_q[cand]) begin
        found    = 1'b1;
        free_idx = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    load_vec = '0;
    if (state_q == LOAD && play) begin
      load_vec = NUM_VOICES'(1) << idx_q;
    end
  end

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    idx_d       = idx_q;
    pend_note_d = pend_note_q;
    pend_dur_d  = pend_dur_q;
    overflow_d  = overflow_q;
    // A load in the same cycle as done keeps the voice busy.
    busy_d      = (busy_q & ~voice_done) | load_vec;

    if (new_note && state_q != IDLE) begin
      overflow_d = 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (new_note && play && duration != '0) begin
          pend_note_d = note;
          pend_dur_d  = duration;
          state_d     = ALLOC;
        end
      end
      ALLOC: begin
        if (play && found) begin
          idx_d   = free_idx;
          state_d = LOAD;
        end
      end
      LOAD: begin
        if (play) begin
          rr_ptr_d = wrap_inc(idx_q);
          state_d  = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    if (flush) begin
      state_d     = IDLE;
      rr_ptr_d    = '0;
      idx_d       = '0;
      pend_note_d = '0;
      pend_dur_d  = '0;
      busy_d      = '0;
      overflow_d  = overflow_q;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= IDLE;
      rr_ptr_q    <= '0;
      idx_q       <= '0;
      pend_note_q <= '0;
      pend_dur_q  <= '0;
      busy_q      <= '0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      idx_q       <= idx_d;
      pend_note_q <= pend_note_d;
      pend_dur_q  <= pend_dur_d;
      busy_q      <= busy_d;
      overflow_q  <= overflow_d;
    end
  end

  assign voice_load     = load_vec;
  assign voice_note     = pend_note_q;
  assign voice_duration = pend_dur_q;
  assign busy           = busy_q;
  assign ready          = (state_q == IDLE);
  assign overflow       = overflow_q;

endmodule

// File: tb/tb_voice_scheduler.sv
// Directed bench for voice_scheduler: expected loads queued at issue time and
// checked by a negedge monitor, plus direct checks of busy/ready/overflow.
module tb_voice_scheduler;

  logic       clk = 1'b0;
  logic       reset_n;
  logic       play, flush, new_note;
  logic [5:0] note, duration;
  logic [2:0] voice_done;
  logic [2:0] voice_load;
  logic [5:0] voice_note, voice_duration;
  logic [2:0] busy;
  logic       ready, overflow;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic [2:0] load;
    logic [5:0] note;
    logic [5:0] dur;
    int         cyc;
  } exp_t;
  exp_t exp_q[$];

  voice_scheduler #(.NUM_VOICES(3), .NOTE_W(6), .DUR_W(6)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .play           (play),
    .flush          (flush),
    .new_note       (new_note),
    .note           (note),
    .duration       (duration),
    .voice_done     (voice_done),
    .voice_load     (voice_load),
    .voice_note     (voice_note),
    .voice_duration (voice_duration),
    .busy           (busy),
    .ready          (ready),
    .overflow       (overflow)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h (cyc %0d)", name, act, exp, cyc);
  endtask

  task automatic expect_load(input logic [2:0] ld, input logic [5:0] nt,
                             input logic [5:0] dr, input int at);
    exp_t e;
    e.load = ld; e.note = nt; e.dur = dr; e.cyc = at;
    exp_q.push_back(e);
  endtask

  task automatic tick(input int n = 1);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [5:0] nt, input logic [5:0] dr);
    new_note = 1'b1; note = nt; duration = dr;
    tick();
    new_note = 1'b0;
  endtask

  // Monitor: every non-zero load strobe must match the head of the queue.
  always @(negedge clk) begin
    if (voice_load !== 3'b000) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_load", {29'd0, voice_load}, 32'd0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        chk("load_vec",  {29'd0, voice_load},     {29'd0, e.load});
        chk("load_note", {26'd0, voice_note},     {26'd0, e.note});
        chk("load_dur",  {26'd0, voice_duration}, {26'd0, e.dur});
        chk("load_cyc",  cyc,                     e.cyc);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset_n = 1'b0; play = 1'b0; flush = 1'b0; new_note = 1'b0;
    note = '0; duration = '0; voice_done = '0;
    #1;
    chk("rst_load",     {29'd0, voice_load}, 32'd0);
    chk("rst_busy",     {29'd0, busy},       32'd0);
    chk("rst_ready",    {31'd0, ready},      32'd1);
    chk("rst_overflow", {31'd0, overflow},   32'd0);
    tick(2);
    reset_n = 1'b1;
    tick();

    // 1: single note, two-cycle latency
    play = 1'b1;
    expect_load(3'b001, 6'd12, 6'd4, cyc + 2);
    send(6'd12, 6'd4);
    chk("t1_ready_low", {31'd0, ready}, 32'd0);
    tick(2);
    chk("t1_busy",  {29'd0, busy},  32'b001);
    chk("t1_ready", {31'd0, ready}, 32'd1);

    // 2: round robin across all voices, 4th waits then takes freed voice 1
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t2_flush_busy", {29'd0, busy}, 32'd0);
    expect_load(3'b001, 6'd20, 6'd5, cyc + 2); send(6'd20, 6'd5); tick(3);
    expect_load(3'b010, 6'd21, 6'd6, cyc + 2); send(6'd21, 6'd6); tick(3);
    expect_load(3'b100, 6'd22, 6'd3, cyc + 2); send(6'd22, 6'd3); tick(3);
    chk("t2_busy_all", {29'd0, busy}, 32'b111);
    send(6'd33, 6'd7);
    tick(5);
    chk("t2_waiting", {31'd0, ready}, 32'd0);
    expect_load(3'b010, 6'd33, 6'd7, cyc + 2);
    voice_done = 3'b010; tick(); voice_done = 3'b000;
    tick(2);
    chk("t2_ready", {31'd0, ready}, 32'd1);
    chk("t2_busy",  {29'd0, busy},  32'b111);

    // 3: second strobe while pending is full -> dropped, overflow sticky
    voice_done = 3'b111; tick(); voice_done = 3'b000;
    chk("t3_busy_clear", {29'd0, busy}, 32'd0);
    expect_load(3'b100, 6'd40, 6'd9, cyc + 2);
    send(6'd40, 6'd9);
    send(6'd50, 6'd3);
    chk("t3_overflow", {31'd0, overflow}, 32'd1);
    tick();
    chk("t3_ready",     {31'd0, ready},    32'd1);
    chk("t3_ovf_stays", {31'd0, overflow}, 32'd1);
    chk("t3_busy",      {29'd0, busy},     32'b100);

    // 4: play pause while in ALLOC
    expect_load(3'b001, 6'd11, 6'd2, cyc + 12);
    send(6'd11, 6'd2);
    play = 1'b0;
    tick(10);
    play = 1'b1;
    tick(2);
    chk("t4_busy", {29'd0, busy}, 32'b101);

    // 5: load and done collide on voice 0; zero duration is dropped
    voice_done = 3'b111; tick(); voice_done = 3'b000;
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t5_flush_keeps_ovf", {31'd0, overflow}, 32'd1);
    expect_load(3'b001, 6'd5, 6'd1, cyc + 2);
    send(6'd5, 6'd1);
    tick();
    voice_done = 3'b001; tick(); voice_done = 3'b000;
    chk("t5_load_wins", {29'd0, busy}, 32'b001);
    send(6'd7, 6'd0);
    chk("t5_dur0_ready", {31'd0, ready}, 32'd1);
    tick(3);
    chk("t5_dur0_busy", {29'd0, busy}, 32'b001);

    // 6: flush in ALLOC with all busy and rr_ptr at 2
    expect_load(3'b010, 6'd60, 6'd4, cyc + 2); send(6'd60, 6'd4); tick(3);
    expect_load(3'b100, 6'd61, 6'd4, cyc + 2); send(6'd61, 6'd4); tick(3);
    send(6'd62, 6'd4); tick(3);
    chk("t6_wait1", {31'd0, ready}, 32'd0);
    expect_load(3'b010, 6'd62, 6'd4, cyc + 2);
    voice_done = 3'b010; tick(); voice_done = 3'b000;
    tick(2);
    send(6'd63, 6'd4); tick(2);
    chk("t6_wait2", {31'd0, ready}, 32'd0);
    flush = 1'b1; tick(); flush = 1'b0;
    chk("t6_busy",     {29'd0, busy},       32'd0);
    chk("t6_ready",    {31'd0, ready},      32'd1);
    chk("t6_overflow", {31'd0, overflow},   32'd1);
    chk("t6_noload",   {29'd0, voice_load}, 32'd0);
    expect_load(3'b001, 6'd64, 6'd8, cyc + 2);
    send(6'd64, 6'd8); tick(3);

    // async reset while the load strobe is high
    send(6'd65, 6'd2);
    tick();
    chk("t6_load_pre_rst", {29'd0, voice_load}, 32'b010);
    reset_n = 1'b0;
    #1;
    chk("t6_rst_load",  {29'd0, voice_load}, 32'd0);
    chk("t6_rst_busy",  {29'd0, busy},       32'd0);
    chk("t6_rst_ready", {31'd0, ready},      32'd1);
    chk("t6_rst_ovf",   {31'd0, overflow},   32'd0);
    tick(2);
    reset_n = 1'b1;
    tick(2);

    chk("sb_empty", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
